// File: rtl/mips_mem_sequencer_pkg.sv
// mips_mem_pkg: shared types and constants for the MIPS memory sequencer.
//   state_e          - sequencer FSM states
//   CAUSE_*          - faultCause encodings (MIPS exception codes)
//   DEFAULT_*_BASE   - byte addresses of .text / .data word 0
package mips_mem_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_LATCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_DWAIT  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic [4:0] CAUSE_NONE = 5'd0;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;

  localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;

endpackage

// File: rtl/mips_mem_sequencer_if.sv
// mips_mem_sequencer_if: datapath, loader and memory signals of the sequencer.
//   datapath : insMemAddress/insMemRead -> insReadValue,
//              dataMemAddress/dataMemRead/dataMemWrite/dataWriteValue -> dataReadValue,
//              advance/fault/faultCause commit strobes
//   loader   : ldValid/ldAddr/ldData -> ldReady
//   memory   : memEn/memWe/memAddr/memWdata -> memRdata (one-cycle read latency)
// slave = sequencer side, master = datapath/loader/memory side.
interface mips_mem_sequencer_if #(
  parameter int MEM_AW = 11
);
  logic [31:0]       insMemAddress;
  logic              insMemRead;
  logic [31:0]       insReadValue;
  logic [31:0]       dataMemAddress;
  logic              dataMemRead;
  logic              dataMemWrite;
  logic [31:0]       dataWriteValue;
  logic [31:0]       dataReadValue;
  logic              advance;
  logic              fault;
  logic [4:0]        faultCause;
  logic              ldValid;
  logic [MEM_AW-1:0] ldAddr;
  logic [31:0]       ldData;
  logic              ldReady;
  logic              memEn;
  logic              memWe;
  logic [MEM_AW-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [31:0]       memRdata;

  modport slave (
    input  insMemAddress, insMemRead, dataMemAddress, dataMemRead, dataMemWrite,
           dataWriteValue, ldValid, ldAddr, ldData, memRdata,
    output insReadValue, dataReadValue, advance, fault, faultCause, ldReady,
           memEn, memWe, memAddr, memWdata
  );

  modport master (
    output insMemAddress, insMemRead, dataMemAddress, dataMemRead, dataMemWrite,
           dataWriteValue, ldValid, ldAddr, ldData, memRdata,
    input  insReadValue, dataReadValue, advance, fault, faultCause, ldReady,
           memEn, memWe, memAddr, memWdata
  );
endinterface

// File: rtl/mips_mem_sequencer_addr_decode.sv
// mips_addr_decode: maps a byte address into a memory word index for one region.
//   addr_i       - byte address to decode
//   base_i       - byte address of region word 0
//   words_i      - region size in words
//   word_index_o - physical memory word index (region word + OFFSET)
//   legal_o      - word aligned and inside the region
module mips_addr_decode #(
  parameter int AW     = 11,
  parameter int OFFSET = 0
) (
  input  logic [31:0]   addr_i,
  input  logic [31:0]   base_i,
  input  logic [31:0]   words_i,
  output logic [AW-1:0] word_index_o,
  output logic          legal_o
);
  logic [31:0] byte_off;
  logic [31:0] word_off;

  // Unsigned wrap makes below-base addresses huge, so they fail the range test.
  assign byte_off     = addr_i - base_i;
  assign word_off     = {2'b00, byte_off[31:2]};
  assign legal_o      = (byte_off[1:0] == 2'b00) && (word_off < words_i);
  assign word_index_o = AW'(word_off + 32'(OFFSET));
endmodule

// File: rtl/mips_mem_sequencer.sv
// mips_mem_sequencer: shares one single-port synchronous memory between
// instruction fetch, data load/store and a boot loader, and strobes advance
// once per instruction so the single-cycle datapath commits exactly once.
//   clock  - single clock, rising edge
//   resetN - asynchronous active-low reset
//   bus    - datapath, loader and memory signals (slave view)
// State table:
//   FETCH  | idle / loader grant / issue instruction read
//   LATCH  | capture instruction from memRdata
//   EXEC   | decode and issue at most one data access
//   DWAIT  | capture load data from memRdata
//   COMMIT | advance strobe, report latched fault
module mips_mem_sequencer
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE  = DEFAULT_TEXT_BASE,
  parameter logic [31:0] DATA_BASE  = DEFAULT_DATA_BASE,
  parameter int          TEXT_WORDS = 1024,
  parameter int          DATA_WORDS = 1024,
  parameter int          MEM_AW     = 11
) (
  input logic                 clock,
  input logic                 resetN,
  mips_mem_sequencer_if.slave bus
);
  state_e            state_q;
  logic [31:0]       ins_q;
  logic [31:0]       dat_q;
  logic              fault_q;
  logic [4:0]        cause_q;

  logic [MEM_AW-1:0] text_idx;
  logic [MEM_AW-1:0] data_idx;
  logic              text_legal;
  logic              data_legal;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              ld_ready;
  logic              commit;

  mips_addr_decode #(.AW(MEM_AW), .OFFSET(0)) u_text_dec (
    .addr_i       (bus.insMemAddress),
    .base_i       (TEXT_BASE),
    .words_i      (32'(TEXT_WORDS)),
    .word_index_o (text_idx),
    .legal_o      (text_legal)
  );

  // Data words sit directly above the text words in the unified memory.
  mips_addr_decode #(.AW(MEM_AW), .OFFSET(TEXT_WORDS)) u_data_dec (
    .addr_i       (bus.dataMemAddress),
    .base_i       (DATA_BASE),
    .words_i      (32'(DATA_WORDS)),
    .word_index_o (data_idx),
    .legal_o      (data_legal)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_FETCH;
      ins_q   <= '0;
      dat_q   <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_FETCH: begin
          // Loader has priority; fetch waits until ldValid drops.
          if (!bus.ldValid && bus.insMemRead) begin
            if (text_legal) begin
              state_q <= ST_LATCH;
            end else begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_ADEL;
              state_q <= ST_COMMIT;
            end
          end
        end
        ST_LATCH: begin
          ins_q   <= bus.memRdata;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (bus.dataMemWrite) begin
            if (!data_legal) begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_ADES;
            end
            state_q <= ST_COMMIT;
          end else if (bus.dataMemRead) begin
            if (data_legal) begin
              state_q <= ST_DWAIT;
            end else begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_ADEL;
              state_q <= ST_COMMIT;
            end
          end else begin
            state_q <= ST_COMMIT;
          end
        end
        ST_DWAIT: begin
          dat_q   <= bus.memRdata;
          state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          fault_q <= 1'b0;
          cause_q <= CAUSE_NONE;
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_ready  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.ldValid) begin
          ld_ready  = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = bus.ldAddr;
          mem_wdata = bus.ldData;
        end else if (bus.insMemRead && text_legal) begin
          mem_en   = 1'b1;
          mem_addr = text_idx;
        end
      end
      ST_EXEC: begin
        if (bus.dataMemWrite) begin
          if (data_legal) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = data_idx;
            mem_wdata = bus.dataWriteValue;
          end
        end else if (bus.dataMemRead && data_legal) begin
          mem_en   = 1'b1;
          mem_addr = data_idx;
        end
      end
      default: ;
    endcase
  end

  assign commit = (state_q == ST_COMMIT);

  assign bus.memEn         = mem_en;
  assign bus.memWe         = mem_we;
  assign bus.memAddr       = mem_addr;
  assign bus.memWdata      = mem_wdata;
  assign bus.ldReady       = ld_ready;
  assign bus.insReadValue  = ins_q;
  assign bus.dataReadValue = dat_q;
  assign bus.advance       = commit;
  assign bus.fault         = commit & fault_q;
  assign bus.faultCause    = commit ? cause_q : CAUSE_NONE;
endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Testbench for mips_mem_sequencer: directed vector table, loader and reset
// corner sequences, then random instructions against a region-rule model.
module tb_mips_mem_sequencer;
  import mips_mem_pkg::*;

  localparam int          MEM_AW = 11;
  localparam int          TW     = 1024;
  localparam int          DW     = 1024;
  localparam int          NWORDS = TW + DW;
  localparam logic [31:0] TB     = 32'h0040_0000;
  localparam logic [31:0] DB     = 32'h1001_0000;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  mips_mem_sequencer_if #(.MEM_AW(MEM_AW)) bus ();

  mips_mem_sequencer #(
    .TEXT_BASE(TB), .DATA_BASE(DB), .TEXT_WORDS(TW), .DATA_WORDS(DW), .MEM_AW(MEM_AW)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  always @(posedge clock) begin
    if (bus.memEn) begin
      if (bus.memWe) mem[bus.memAddr] <= bus.memWdata;
      else           bus.memRdata     <= mem[bus.memAddr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Spec rule: aligned and (addr-base)/4 < words, with 32-bit wrapping subtraction.
  function automatic void region(input logic [31:0] a, input logic [31:0] base, input int words,
                                 output logic ok, output int idx);
    logic [31:0] off;
    off = a - base;
    ok  = (off % 4 == 0) && ((off / 4) < 32'(words));
    idx = int'(off / 4);
  endfunction

  task automatic load_word(input int idx, input logic [31:0] val);
    @(negedge clock);
    bus.ldValid = 1'b1;
    bus.ldAddr  = MEM_AW'(idx);
    bus.ldData  = val;
    #1;
    for (int w = 0; w < 8 && !bus.ldReady; w++) begin
      @(negedge clock);
      #1;
    end
    if (!bus.ldReady) chk("loader_grant", 32'(bus.ldReady), 32'd1);
    ref_mem[idx] = val;
  endtask

  task automatic do_instr(input logic [31:0] pc, input logic rd, input logic wr,
                          input logic [31:0] da, input logic [31:0] wd,
                          output int lat, output logic flt, output logic [4:0] cause,
                          output logic [31:0] ins, output logic [31:0] dat,
                          output int nen, output int nwe, output logic [31:0] we_addr);
    @(negedge clock);
    bus.insMemAddress  = pc;
    bus.insMemRead     = 1'b1;
    bus.dataMemAddress = da;
    bus.dataMemRead    = rd;
    bus.dataMemWrite   = wr;
    bus.dataWriteValue = wd;
    lat = -1; flt = 1'b0; cause = '0; ins = '0; dat = '0; nen = 0; nwe = 0;
    we_addr = 32'hFFFF_FFFF;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      #1;
      if (bus.memEn) nen++;
      if (bus.memEn && bus.memWe) begin
        nwe++;
        we_addr = 32'(bus.memAddr);
      end
      if (bus.advance) begin
        lat   = k;
        flt   = bus.fault;
        cause = bus.faultCause;
        ins   = bus.insReadValue;
        break;
      end
    end
    @(negedge clock);
    dat = bus.dataReadValue;
    bus.insMemRead   = 1'b0;
    bus.dataMemRead  = 1'b0;
    bus.dataMemWrite = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        rd;
    logic        wr;
    logic [31:0] da;
    logic [31:0] wd;
    int          lat;
    logic        flt;
    logic [4:0]  cause;
    int          nen;
    int          nwe;
    int          we_idx;
    logic        chk_ins;
    logic [31:0] ins;
    logic        chk_dat;
    logic [31:0] dat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          lat, nen, nwe;
    logic        flt;
    logic [4:0]  cause;
    logic [31:0] ins, dat, we_addr;

    vecs[0]  = '{TB,             0, 0, 32'h0,          32'h0,          3, 0, 5'd0, 0, 0, 0,       1, 32'h2409_0034, 0, 32'h0};
    vecs[1]  = '{TB + 32'd4,     1, 0, DB + 32'd8,     32'h0,          4, 0, 5'd0, 1, 0, 0,       1, 32'h8D09_0008, 1, 32'hDEAD_BEEF};
    vecs[2]  = '{TB + 32'd8,     0, 1, DB + 32'd4,     32'h1234_5678,  3, 0, 5'd0, 1, 1, TW + 1,  1, 32'hAD0B_0004, 0, 32'h0};
    vecs[3]  = '{TB + 32'd12,    1, 0, DB + 32'd2,     32'h0,          3, 1, 5'd4, 0, 0, 0,       1, 32'h8D0A_0002, 0, 32'h0};
    vecs[4]  = '{TB + 32'd16,    0, 1, 32'h0FFF_FFFC,  32'h5555_0000,  3, 1, 5'd5, 0, 0, 0,       1, 32'hAD0B_FFFC, 0, 32'h0};
    vecs[5]  = '{TB + 32'd2,     0, 0, 32'h0,          32'h0,          1, 1, 5'd4, 0, 0, 0,       0, 32'h0,         0, 32'h0};
    vecs[6]  = '{32'h003F_FFFC,  0, 0, 32'h0,          32'h0,          1, 1, 5'd4, 0, 0, 0,       0, 32'h0,         0, 32'h0};
    vecs[7]  = '{TB + 32'hFFC,   0, 0, 32'h0,          32'h0,          3, 0, 5'd0, 0, 0, 0,       1, 32'h0000_000C, 0, 32'h0};
    vecs[8]  = '{TB + 32'h1000,  1, 0, DB,             32'h0,          1, 1, 5'd4, 0, 0, 0,       0, 32'h0,         0, 32'h0};
    vecs[9]  = '{TB + 32'd20,    1, 0, DB + 32'hFFC,   32'h0,          4, 0, 5'd0, 1, 0, 0,       1, 32'h8C0C_0FFC, 1, 32'hCAFE_F00D};
    vecs[10] = '{TB + 32'd24,    1, 1, DB + 32'd16,    32'hA5A5_A5A5,  3, 0, 5'd0, 1, 1, TW + 4,  1, 32'hAD0D_0010, 0, 32'h0};
    vecs[11] = '{TB + 32'd28,    1, 0, DB + 32'h1000,  32'h0,          3, 1, 5'd4, 0, 0, 0,       1, 32'h8C0E_1000, 0, 32'h0};

    bus.insMemAddress = '0; bus.insMemRead = 1'b0;
    bus.dataMemAddress = '0; bus.dataMemRead = 1'b0; bus.dataMemWrite = 1'b0;
    bus.dataWriteValue = '0;
    bus.ldValid = 1'b0; bus.ldAddr = '0; bus.ldData = '0;

    // Reset state
    #3;
    chk("rst_advance",   32'(bus.advance),    32'd0);
    chk("rst_fault",     32'(bus.fault),      32'd0);
    chk("rst_cause",     32'(bus.faultCause), 32'd0);
    chk("rst_ins",       bus.insReadValue,    32'd0);
    chk("rst_dat",       bus.dataReadValue,   32'd0);
    chk("rst_memEn",     32'(bus.memEn),      32'd0);
    chk("rst_memWe",     32'(bus.memWe),      32'd0);
    chk("rst_ldReady",   32'(bus.ldReady),    32'd0);
    @(negedge clock);
    resetN = 1'b1;

    // Fill the whole memory through the loader port.
    for (int i = 0; i < NWORDS; i++) load_word(i, $urandom);
    for (int r = 0; r < 12; r++)
      if (vecs[r].chk_ins) load_word(int'((vecs[r].pc - TB) >> 2), vecs[r].ins);
    load_word(TW + 2, 32'hDEAD_BEEF);
    load_word(TW + 1023, 32'hCAFE_F00D);
    @(negedge clock);
    bus.ldValid = 1'b0;

    // Directed vector table
    for (int r = 0; r < 12; r++) begin
      do_instr(vecs[r].pc, vecs[r].rd, vecs[r].wr, vecs[r].da, vecs[r].wd,
               lat, flt, cause, ins, dat, nen, nwe, we_addr);
      chk($sformatf("vec%0d_latency", r), 32'(lat),   32'(vecs[r].lat));
      chk($sformatf("vec%0d_fault", r),   32'(flt),   32'(vecs[r].flt));
      chk($sformatf("vec%0d_cause", r),   32'(cause), 32'(vecs[r].cause));
      chk($sformatf("vec%0d_memEn", r),   32'(nen),   32'(vecs[r].nen));
      chk($sformatf("vec%0d_memWe", r),   32'(nwe),   32'(vecs[r].nwe));
      if (vecs[r].nwe != 0) begin
        chk($sformatf("vec%0d_wr_addr", r), we_addr, 32'(vecs[r].we_idx));
        ref_mem[vecs[r].we_idx] = vecs[r].wd;
      end
      if (vecs[r].chk_ins) chk($sformatf("vec%0d_ins", r), ins, vecs[r].ins);
      if (vecs[r].chk_dat) chk($sformatf("vec%0d_dat", r), dat, vecs[r].dat);
    end
    chk("store_word_1025", mem[TW + 1], 32'h1234_5678);
    chk("store_word_1028", mem[TW + 4], 32'hA5A5_A5A5);

    // Loader holds ldValid for 3 cycles while a fetch is pending.
    @(negedge clock);
    bus.insMemAddress = TB + 32'd20;
    bus.insMemRead    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.ldValid = 1'b1;
      bus.ldAddr  = MEM_AW'(100 + c);
      bus.ldData  = 32'hB000_0000 + 32'(c);
      #1;
      chk($sformatf("ld%0d_ready", c), 32'(bus.ldReady), 32'd1);
      chk($sformatf("ld%0d_we", c),    32'(bus.memWe),   32'd1);
      chk($sformatf("ld%0d_addr", c),  32'(bus.memAddr), 32'(100 + c));
      ref_mem[100 + c] = 32'hB000_0000 + 32'(c);
      @(negedge clock);
    end
    bus.ldValid = 1'b0;
    #1;
    chk("ld_fetch_ready", 32'(bus.ldReady), 32'd0);
    chk("ld_fetch_en",    32'(bus.memEn),   32'd1);
    chk("ld_fetch_we",    32'(bus.memWe),   32'd0);
    chk("ld_fetch_addr",  32'(bus.memAddr), 32'd5);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      #1;
      if (bus.advance) begin
        lat = k;
        ins = bus.insReadValue;
        break;
      end
    end
    chk("ld_fetch_latency", 32'(lat), 32'd3);
    chk("ld_fetch_ins",     ins,      ref_mem[5]);
    @(negedge clock);
    bus.insMemRead = 1'b0;
    for (int c = 0; c < 3; c++) chk($sformatf("ld%0d_stored", c), mem[100 + c], ref_mem[100 + c]);

    // Reset asserted while a load sits in DWAIT.
    @(negedge clock);
    bus.insMemAddress  = TB;
    bus.insMemRead     = 1'b1;
    bus.dataMemAddress = DB + 32'd8;
    bus.dataMemRead    = 1'b1;
    for (int k = 0; k < 3; k++) @(posedge clock);
    #1;
    chk("dwait_no_advance", 32'(bus.advance), 32'd0);
    resetN = 1'b0;
    bus.insMemRead  = 1'b0;
    bus.dataMemRead = 1'b0;
    #1;
    chk("mid_rst_advance", 32'(bus.advance),    32'd0);
    chk("mid_rst_fault",   32'(bus.fault),      32'd0);
    chk("mid_rst_cause",   32'(bus.faultCause), 32'd0);
    chk("mid_rst_ins",     bus.insReadValue,    32'd0);
    chk("mid_rst_dat",     bus.dataReadValue,   32'd0);
    chk("mid_rst_memEn",   32'(bus.memEn),      32'd0);
    chk("mid_rst_ldReady", 32'(bus.ldReady),    32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      chk("mid_rst_hold_advance", 32'(bus.advance), 32'd0);
    end
    @(negedge clock);
    resetN = 1'b1;
    do_instr(TB + 32'd4, 1'b0, 1'b0, 32'h0, 32'h0, lat, flt, cause, ins, dat, nen, nwe, we_addr);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_ins",     ins,      ref_mem[1]);

    // Random instructions against the region-rule model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] pc, da, wd, e_ins, e_dat;
      logic        rd, wr, tok, dok, e_flt;
      logic [4:0]  e_cause;
      int          ti, di, e_lat, e_nen, e_nwe, op;
      case ($urandom_range(0, 5))
        0, 1, 2, 3: pc = TB + 32'($urandom_range(0, TW - 1)) * 4;
        4:          pc = TB + 32'($urandom_range(0, TW - 1)) * 4 + 32'($urandom_range(1, 3));
        default:    pc = ($urandom_range(0, 1) == 0) ? TB - 32'd4 : TB + 32'(TW) * 4;
      endcase
      case ($urandom_range(0, 5))
        0, 1, 2, 3: da = DB + 32'($urandom_range(0, DW - 1)) * 4;
        4:          da = DB + 32'($urandom_range(0, DW - 1)) * 4 + 32'($urandom_range(1, 3));
        default:    da = ($urandom_range(0, 1) == 0) ? DB - 32'd4 : DB + 32'(DW) * 4;
      endcase
      op = int'($urandom_range(0, 3));
      rd = (op == 1) || (op == 3);
      wr = (op == 2) || (op == 3);
      wd = $urandom;

      region(pc, TB, TW, tok, ti);
      region(da, DB, DW, dok, di);
      e_flt = 1'b0; e_cause = 5'd0; e_nen = 0; e_nwe = 0; e_ins = 32'h0; e_dat = 32'h0;
      if (!tok) begin
        e_lat = 1; e_flt = 1'b1; e_cause = 5'd4;
      end else begin
        e_ins = ref_mem[ti];
        e_lat = 3;
        if (wr) begin
          if (dok) begin e_nen = 1; e_nwe = 1; end
          else begin e_flt = 1'b1; e_cause = 5'd5; end
        end else if (rd) begin
          if (dok) begin e_lat = 4; e_nen = 1; e_dat = ref_mem[TW + di]; end
          else begin e_flt = 1'b1; e_cause = 5'd4; end
        end
      end

      do_instr(pc, rd, wr, da, wd, lat, flt, cause, ins, dat, nen, nwe, we_addr);
      chk($sformatf("rnd%0d_latency", n), 32'(lat),   32'(e_lat));
      chk($sformatf("rnd%0d_fault", n),   32'(flt),   32'(e_flt));
      chk($sformatf("rnd%0d_cause", n),   32'(cause), 32'(e_cause));
      chk($sformatf("rnd%0d_memEn", n),   32'(nen),   32'(e_nen));
      chk($sformatf("rnd%0d_memWe", n),   32'(nwe),   32'(e_nwe));
      if (tok) chk($sformatf("rnd%0d_ins", n), ins, e_ins);
      if (tok && !wr && rd && dok) chk($sformatf("rnd%0d_dat", n), dat, e_dat);
      if (e_nwe != 0) begin
        chk($sformatf("rnd%0d_wr_addr", n), we_addr, 32'(TW + di));
        ref_mem[TW + di] = wd;
      end
    end

    begin
      int diffs = 0;
      for (int i = 0; i < NWORDS; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_image_diffs", 32'(diffs), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
